// File: rtl/mpc_mac_acc_29s.sv
// Dot-product accumulator behind the 21s x 7u DSP48 multiplier: aligns tags with the product,
// sums each first..last run, rescales, and holds the result in a valid/ready register.
// Optional `MPC_ACC_SAT_EN clamps the result to OUT_W bits; otherwise the result wraps.
module mpc_mac_acc_29s #(
    parameter int MUL_LAT = 4,
    parameter int P_W     = 29,
    parameter int ACC_W   = 36,
    parameter int SHIFT   = 6,
    parameter int OUT_W   = 24
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ce,
    input  logic             in_valid,
    input  logic             in_first,
    input  logic             in_last,
    input  logic [P_W-1:0]   p,
    output logic [OUT_W-1:0] out_data,
    output logic             out_sat,
    output logic             out_valid,
    input  logic             out_ready,
    input  logic             clr_err,
    output logic             err_ovf,
    output logic             err_seq
);

    typedef struct packed {
        logic valid;
        logic first;
        logic last;
    } tag_t;

    tag_t                     tag_pipe [MUL_LAT];
    tag_t                     tag_out;
    logic signed [ACC_W-1:0]  acc;
    logic signed [ACC_W-1:0]  acc_n;
    logic signed [ACC_W-1:0]  p_ext;
    logic                     sum_open;
    logic                     acc_step;
    logic                     load;
    logic                     seq_evt;
    logic                     ovf_evt;
    logic [OUT_W-1:0]         r_data;
    logic                     r_sat;

    assign tag_out = tag_pipe[MUL_LAT-1];

    // Tag delay line mirrors the multiplier pipeline so the last stage lines up with p.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < MUL_LAT; i++) tag_pipe[i] <= '0;
        end else if (ce) begin
            // NOTE: non-blocking so every stage samples its neighbour's pre-edge value.
            tag_pipe[0] <= '{valid: in_valid, first: in_first, last: in_last};
            for (int i = 1; i < MUL_LAT; i++) tag_pipe[i] <= tag_pipe[i-1];
        end
    end

    always_comb begin
        // NOTE: every combinational output gets a default first so no latch can be inferred.
        p_ext    = {{(ACC_W-P_W){p[P_W-1]}}, p};
        acc_step = ce & tag_out.valid;
        acc_n    = tag_out.first ? p_ext : acc + p_ext;
        load     = acc_step & tag_out.last;
        seq_evt  = acc_step & tag_out.first & sum_open;
        ovf_evt  = load & out_valid & ~out_ready;
    end

`ifdef MPC_ACC_SAT_EN
    localparam logic signed [ACC_W-1:0] R_MAX = ACC_W'((64'sd1 <<< (OUT_W-1)) - 64'sd1);
    localparam logic signed [ACC_W-1:0] R_MIN = ~R_MAX;

    logic signed [ACC_W-1:0] r_full;

    always_comb begin
        r_full = acc_n >>> SHIFT;
        r_data = r_full[OUT_W-1:0];
        r_sat  = 1'b0;
        if (r_full > R_MAX) begin
            r_data = R_MAX[OUT_W-1:0];
            r_sat  = 1'b1;
        end else if (r_full < R_MIN) begin
            r_data = R_MIN[OUT_W-1:0];
            r_sat  = 1'b1;
        end
    end
`else
    // Arithmetic shift then truncation is just a bit-slice of the sum.
    always_comb begin
        r_data = acc_n[SHIFT +: OUT_W];
        r_sat  = 1'b0;
    end
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            acc      <= '0;
            sum_open <= 1'b0;
        end else if (acc_step) begin
            if (tag_out.last) begin
                acc      <= '0;
                sum_open <= 1'b0;
            end else begin
                acc      <= acc_n;
                sum_open <= 1'b1;
            end
        end
    end

    // Output register runs every clk regardless of ce; a load beats a same-cycle accept.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_data  <= '0;
            out_sat   <= 1'b0;
            out_valid <= 1'b0;
            err_ovf   <= 1'b0;
            err_seq   <= 1'b0;
        end else begin
            if (load) begin
                out_data  <= r_data;
                out_sat   <= r_sat;
                out_valid <= 1'b1;
            end else if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
            err_ovf <= ovf_evt | (err_ovf & ~clr_err);
            err_seq <= seq_evt | (err_seq & ~clr_err);
        end
    end

endmodule
